// File: rtl/dtcm_arbiter_pkg.sv
// Shared types and sizing constants for the two-port DTCM arbiter.
// The arbiter, its ID queue and any bench import this package.
package dtcm_arbiter_pkg;

    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int XLEN            = 32;
    localparam int DTCM_ARB_NPORT  = 2;
    localparam int DTCM_ARB_ID_W   = 1;

    typedef enum logic [DTCM_ARB_ID_W-1:0] {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_id_e;

    // Pointer width for a queue of the given depth (never zero bits).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dtcm_arb_id_fifo.sv
// In-order queue of requester IDs, one entry per outstanding DTCM transaction.
// A push is accepted while full only when the head is popped in the same cycle.
module dtcm_arb_id_fifo
    import dtcm_arbiter_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = DTCM_ARB_ID_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/dtcm_arbiter.sv
// Round-robin arbiter sharing one DTCM port between LSU (m0) and debug (m1),
// with grant lock while stalled and in-order response routing by owner ID.
module dtcm_arbiter
    import dtcm_arbiter_pkg::*;
#(
    parameter int AW      = DTCM_ADDR_WIDTH,
    parameter int DW      = XLEN,
    parameter int OUTS_DP = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cmd_valid,
    output logic            m0_cmd_ready,
    input  logic            m0_cmd_read,
    input  logic [AW-1:0]   m0_cmd_addr,
    input  logic [DW-1:0]   m0_cmd_wdata,
    input  logic [DW/8-1:0] m0_cmd_wmask,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_rdata,
    input  logic            m1_cmd_valid,
    output logic            m1_cmd_ready,
    input  logic            m1_cmd_read,
    input  logic [AW-1:0]   m1_cmd_addr,
    input  logic [DW-1:0]   m1_cmd_wdata,
    input  logic [DW/8-1:0] m1_cmd_wmask,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            dtcm_cmd_valid,
    input  logic            dtcm_cmd_ready,
    output logic            dtcm_cmd_read,
    output logic [AW-1:0]   dtcm_cmd_addr,
    output logic [DW-1:0]   dtcm_cmd_wdata,
    output logic [DW/8-1:0] dtcm_cmd_wmask,
    input  logic            dtcm_rsp_valid,
    output logic            dtcm_rsp_ready,
    input  logic [DW-1:0]   dtcm_rsp_rdata
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and a stalled command holds its payload.

    port_id_e r_ptr;
    port_id_e r_lock_id;
    logic     r_lock_vld;

    port_id_e                   w_grant;
    logic [DTCM_ARB_ID_W-1:0]   w_push_id;
    logic [DTCM_ARB_ID_W-1:0]   w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_own_m1;
    logic                       w_own_rsp_ready;
    logic                       w_rsp_hs;
    logic                       w_cmd_hs;
    logic                       w_room;
    logic                       w_win_valid;

    always_comb begin
        w_grant = r_ptr;
        if (r_lock_vld) begin
            w_grant = r_lock_id;
        end else if (m0_cmd_valid && !m1_cmd_valid) begin
            w_grant = PORT_M0;
        end else if (m1_cmd_valid && !m0_cmd_valid) begin
            w_grant = PORT_M1;
        end
    end

    assign w_own_m1        = (w_head == DTCM_ARB_ID_W'(PORT_M1));
    assign w_own_rsp_ready = w_own_m1 ? m1_rsp_ready : m0_rsp_ready;
    assign dtcm_rsp_ready  = rst_n && !w_empty && w_own_rsp_ready;
    assign w_rsp_hs        = dtcm_rsp_valid && dtcm_rsp_ready;

    // A response leaving this cycle frees a slot, so a full queue still
    // accepts a command alongside it and throughput holds at depth 1.
    assign w_room      = !w_full || w_rsp_hs;
    assign w_win_valid = (w_grant == PORT_M1) ? m1_cmd_valid : m0_cmd_valid;

    assign dtcm_cmd_valid = rst_n && w_win_valid && w_room;
    assign m0_cmd_ready   = rst_n && (w_grant == PORT_M0) && dtcm_cmd_ready && w_room;
    assign m1_cmd_ready   = rst_n && (w_grant == PORT_M1) && dtcm_cmd_ready && w_room;
    assign w_cmd_hs       = dtcm_cmd_valid && dtcm_cmd_ready;
    assign w_push_id      = w_grant;

    always_comb begin
        dtcm_cmd_read  = m0_cmd_read;
        dtcm_cmd_addr  = m0_cmd_addr;
        dtcm_cmd_wdata = m0_cmd_wdata;
        dtcm_cmd_wmask = m0_cmd_wmask;
        if (w_grant == PORT_M1) begin
            dtcm_cmd_read  = m1_cmd_read;
            dtcm_cmd_addr  = m1_cmd_addr;
            dtcm_cmd_wdata = m1_cmd_wdata;
            dtcm_cmd_wmask = m1_cmd_wmask;
        end
    end

    assign m0_rsp_valid = rst_n && !w_empty && !w_own_m1 && dtcm_rsp_valid;
    assign m1_rsp_valid = rst_n && !w_empty && w_own_m1 && dtcm_rsp_valid;
    assign m0_rsp_rdata = (!w_empty && !w_own_m1) ? dtcm_rsp_rdata : '0;
    assign m1_rsp_rdata = (!w_empty && w_own_m1) ? dtcm_rsp_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= PORT_M0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= PORT_M0;
        end else if (w_cmd_hs) begin
            r_ptr      <= (w_grant == PORT_M0) ? PORT_M1 : PORT_M0;
            r_lock_vld <= 1'b0;
        end else if (dtcm_cmd_valid) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_grant;
        end
    end

    dtcm_arb_id_fifo #(
        .DEPTH (OUTS_DP),
        .W     (DTCM_ARB_ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cmd_hs),
        .i_data  (w_push_id),
        .i_pop   (w_rsp_hs),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A response with nothing outstanding has no owner to route to.
    a_rsp_needs_owner: assert property (@(posedge clk) disable iff (!rst_n)
        !(dtcm_rsp_valid && w_empty));

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Bench for dtcm_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based behavioural model.
module tb_dtcm_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [AW-1:0] m0_cmd_addr;
    logic [DW-1:0] m0_cmd_wdata;
    logic [MW-1:0] m0_cmd_wmask;
    logic          m0_rsp_valid, m0_rsp_ready;
    logic [DW-1:0] m0_rsp_rdata;
    logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [AW-1:0] m1_cmd_addr;
    logic [DW-1:0] m1_cmd_wdata;
    logic [MW-1:0] m1_cmd_wmask;
    logic          m1_rsp_valid, m1_rsp_ready;
    logic [DW-1:0] m1_rsp_rdata;
    logic          dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
    logic [AW-1:0] dtcm_cmd_addr;
    logic [DW-1:0] dtcm_cmd_wdata;
    logic [MW-1:0] dtcm_cmd_wmask;
    logic          dtcm_rsp_valid, dtcm_rsp_ready;
    logic [DW-1:0] dtcm_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: owner queue, favoured port, locked winner.
    bit md_q[$];
    bit md_ptr, md_lock_v, md_lock_id, md_hold0, md_hold1;
    bit e_grant, e_head, e_rsp_rdy, e_pop, e_room, e_cv, e_hs;
    int e_nq;

    dtcm_arbiter #(.AW(AW), .DW(DW), .OUTS_DP(DP)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_cmd_valid   (m0_cmd_valid),
        .m0_cmd_ready   (m0_cmd_ready),
        .m0_cmd_read    (m0_cmd_read),
        .m0_cmd_addr    (m0_cmd_addr),
        .m0_cmd_wdata   (m0_cmd_wdata),
        .m0_cmd_wmask   (m0_cmd_wmask),
        .m0_rsp_valid   (m0_rsp_valid),
        .m0_rsp_ready   (m0_rsp_ready),
        .m0_rsp_rdata   (m0_rsp_rdata),
        .m1_cmd_valid   (m1_cmd_valid),
        .m1_cmd_ready   (m1_cmd_ready),
        .m1_cmd_read    (m1_cmd_read),
        .m1_cmd_addr    (m1_cmd_addr),
        .m1_cmd_wdata   (m1_cmd_wdata),
        .m1_cmd_wmask   (m1_cmd_wmask),
        .m1_rsp_valid   (m1_rsp_valid),
        .m1_rsp_ready   (m1_rsp_ready),
        .m1_rsp_rdata   (m1_rsp_rdata),
        .dtcm_cmd_valid (dtcm_cmd_valid),
        .dtcm_cmd_ready (dtcm_cmd_ready),
        .dtcm_cmd_read  (dtcm_cmd_read),
        .dtcm_cmd_addr  (dtcm_cmd_addr),
        .dtcm_cmd_wdata (dtcm_cmd_wdata),
        .dtcm_cmd_wmask (dtcm_cmd_wmask),
        .dtcm_rsp_valid (dtcm_rsp_valid),
        .dtcm_rsp_ready (dtcm_rsp_ready),
        .dtcm_rsp_rdata (dtcm_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_wmask = '0;
        m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_wmask = '0;
        m0_rsp_ready = 0; m1_rsp_ready = 0;
        dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
    endtask

    task automatic drive_m0(input logic rd, input logic [AW-1:0] a);
        m0_cmd_valid = 1; m0_cmd_read = rd; m0_cmd_addr = a;
        m0_cmd_wdata = {16'h0d00, a}; m0_cmd_wmask = 4'hf;
    endtask

    task automatic drive_m1(input logic rd, input logic [AW-1:0] a);
        m1_cmd_valid = 1; m1_cmd_read = rd; m1_cmd_addr = a;
        m1_cmd_wdata = {16'h1d00, a}; m1_cmd_wmask = 4'h3;
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m0_cmd_ready", m0_cmd_ready, 0);
            chk("rst_m1_cmd_ready", m1_cmd_ready, 0);
            chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
            chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
            chk("rst_dtcm_cmd_valid", dtcm_cmd_valid, 0);
            chk("rst_dtcm_rsp_ready", dtcm_rsp_ready, 0);
            md_q.delete();
            md_ptr = 0; md_lock_v = 0; md_lock_id = 0; md_hold0 = 0; md_hold1 = 0;
        end else begin
            if (md_lock_v)                        e_grant = md_lock_id;
            else if (m0_cmd_valid && !m1_cmd_valid) e_grant = 0;
            else if (m1_cmd_valid && !m0_cmd_valid) e_grant = 1;
            else                                  e_grant = md_ptr;
            e_nq      = md_q.size();
            e_head    = (e_nq > 0) ? md_q[0] : 1'b0;
            e_rsp_rdy = (e_nq > 0) && (e_head ? m1_rsp_ready : m0_rsp_ready);
            e_pop     = dtcm_rsp_valid && e_rsp_rdy;
            e_room    = (e_nq < DP) || e_pop;
            e_cv      = (e_grant ? m1_cmd_valid : m0_cmd_valid) && e_room;
            e_hs      = e_cv && dtcm_cmd_ready;
            chk("dtcm_cmd_valid", dtcm_cmd_valid, e_cv);
            chk("m0_cmd_ready", m0_cmd_ready, !e_grant && dtcm_cmd_ready && e_room);
            chk("m1_cmd_ready", m1_cmd_ready, e_grant && dtcm_cmd_ready && e_room);
            if (e_cv) begin
                chk("dtcm_cmd_read", dtcm_cmd_read, e_grant ? m1_cmd_read : m0_cmd_read);
                chk("dtcm_cmd_addr", dtcm_cmd_addr, e_grant ? m1_cmd_addr : m0_cmd_addr);
                chk("dtcm_cmd_wdata", dtcm_cmd_wdata, e_grant ? m1_cmd_wdata : m0_cmd_wdata);
                chk("dtcm_cmd_wmask", dtcm_cmd_wmask, e_grant ? m1_cmd_wmask : m0_cmd_wmask);
            end
            chk("dtcm_rsp_ready", dtcm_rsp_ready, e_rsp_rdy);
            chk("m0_rsp_valid", m0_rsp_valid, dtcm_rsp_valid && (e_nq > 0) && !e_head);
            chk("m1_rsp_valid", m1_rsp_valid, dtcm_rsp_valid && (e_nq > 0) && e_head);
            if (e_nq > 0) begin
                chk("owner_rdata", e_head ? m1_rsp_rdata : m0_rsp_rdata, dtcm_rsp_rdata);
                chk("other_rdata", e_head ? m0_rsp_rdata : m1_rsp_rdata, 0);
            end
            if (e_pop) void'(md_q.pop_front());
            if (e_hs) begin
                md_q.push_back(e_grant);
                md_ptr    = !e_grant;
                md_lock_v = 0;
            end else if (e_cv) begin
                md_lock_v  = 1;
                md_lock_id = e_grant;
            end
            md_hold0 = m0_cmd_valid && !(e_hs && !e_grant);
            md_hold1 = m1_cmd_valid && !(e_hs && e_grant);
        end
    end

    initial begin
        rst_n = 0;
        idle();
        repeat (3) cyc();

        // Single m0 read, response one cycle later.
        cyc(); rst_n = 1; drive_m0(1, 16'h0010); dtcm_cmd_ready = 1;
        @(negedge clk);
        chk("d1_m0_ready", m0_cmd_ready, 1);
        chk("d1_addr", dtcm_cmd_addr, 16'h0010);
        cyc(); idle(); dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hdeadbeef; m0_rsp_ready = 1;
        @(negedge clk);
        chk("d1_m0_rsp_valid", m0_rsp_valid, 1);
        chk("d1_m0_rdata", m0_rsp_rdata, 32'hdeadbeef);
        chk("d1_m1_rsp_valid", m1_rsp_valid, 0);

        // Both ports hammering: grants alternate starting at m0 after reset.
        cyc(); idle(); rst_n = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(); idle(); rst_n = 1;
            if (i < 6) begin
                drive_m0(1, AW'(16'h0100 + i));
                drive_m1(1, AW'(16'h0200 + i));
            end
            dtcm_cmd_ready = 1;
            dtcm_rsp_valid = (i > 0);
            dtcm_rsp_rdata = 32'ha0000000 + i;
            m0_rsp_ready = 1; m1_rsp_ready = 1;
            @(negedge clk);
            if (i < 6) chk("d2_grant_addr", dtcm_cmd_addr, (i % 2 == 0) ? 16'h0100 + i : 16'h0200 + i);
            if (i > 0) begin
                chk("d2_m0_rsp_valid", m0_rsp_valid, ((i - 1) % 2) == 0);
                chk("d2_m1_rsp_valid", m1_rsp_valid, ((i - 1) % 2) == 1);
            end
        end

        // m1 stalled three cycles holds its grant against m0.
        cyc(); idle(); drive_m1(0, 16'h0300);
        @(negedge clk);
        chk("d3_lock_addr0", dtcm_cmd_addr, 16'h0300);
        chk("d3_m1_ready0", m1_cmd_ready, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(); drive_m0(0, 16'h00aa);
            @(negedge clk);
            chk("d3_lock_addr", dtcm_cmd_addr, 16'h0300);
            chk("d3_m0_ready", m0_cmd_ready, 0);
        end
        cyc(); dtcm_cmd_ready = 1;
        @(negedge clk);
        chk("d3_m1_hs", m1_cmd_ready, 1);
        chk("d3_m0_blocked", m0_cmd_ready, 0);
        cyc(); m1_cmd_valid = 0;
        @(negedge clk);
        chk("d3_m0_next", m0_cmd_ready, 1);
        chk("d3_m0_addr", dtcm_cmd_addr, 16'h00aa);
        cyc(); idle(); dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h11111111; m0_rsp_ready = 1; m1_rsp_ready = 1;
        @(negedge clk);
        chk("d3_rsp_m1", m1_rsp_valid, 1);
        chk("d3_rsp_m1_data", m1_rsp_rdata, 32'h11111111);
        cyc(); dtcm_rsp_rdata = 32'h22222222;
        @(negedge clk);
        chk("d3_rsp_m0", m0_rsp_valid, 1);

        // Queue full at two outstanding; response frees a slot in the same cycle.
        cyc(); idle(); drive_m0(0, 16'h0040); dtcm_cmd_ready = 1;
        cyc(); drive_m0(0, 16'h0044);
        cyc(); drive_m0(0, 16'h0048);
        @(negedge clk);
        chk("d4_full_ready", m0_cmd_ready, 0);
        chk("d4_full_valid", dtcm_cmd_valid, 0);
        cyc(); dtcm_rsp_valid = 1; m0_rsp_ready = 1;
        @(negedge clk);
        chk("d4_bypass_ready", m0_cmd_ready, 1);
        chk("d4_bypass_rsp", m0_rsp_valid, 1);
        cyc(); dtcm_rsp_valid = 0; drive_m0(0, 16'h004c);
        @(negedge clk);
        chk("d4_still_full", m0_cmd_ready, 0);
        cyc(); m0_cmd_valid = 0; dtcm_rsp_valid = 1;
        cyc();
        cyc(); idle();

        // Response backpressure from m0.
        cyc(); drive_m0(1, 16'h0050); dtcm_cmd_ready = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h5a5a0000 + i;
            @(negedge clk);
            chk("d5_stall_ready", dtcm_rsp_ready, 0);
            chk("d5_stall_valid", m0_rsp_valid, 1);
        end
        cyc(); m0_rsp_ready = 1;
        @(negedge clk);
        chk("d5_deliver", dtcm_rsp_ready, 1);
        chk("d5_rdata", m0_rsp_rdata, 32'h5a5a0001);
        cyc(); idle(); m0_rsp_ready = 1;
        @(negedge clk);
        chk("d5_popped_once", dtcm_rsp_ready, 0);

        // Reset with one outstanding: queue, lock and pointer discarded.
        cyc(); idle(); drive_m1(1, 16'h0060); dtcm_cmd_ready = 1;
        cyc(); idle(); rst_n = 0; drive_m0(1, 16'h0064); dtcm_cmd_ready = 1;
        dtcm_rsp_valid = 1; m1_rsp_ready = 1;
        @(negedge clk);
        chk("d6_rst_ready", m0_cmd_ready, 0);
        chk("d6_rst_rsp", m1_rsp_valid, 0);
        cyc(); idle(); rst_n = 1; drive_m0(1, 16'h0070); drive_m1(1, 16'h0074);
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        @(negedge clk);
        chk("d6_ptr_m0", dtcm_cmd_addr, 16'h0070);
        chk("d6_q_empty", dtcm_rsp_ready, 0);
        cyc(); m1_cmd_valid = 0; dtcm_cmd_ready = 1;
        @(negedge clk);
        chk("d6_m0_hs", m0_cmd_ready, 1);
        cyc(); m0_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h00c0ffee;
        @(negedge clk);
        chk("d6_rsp_m0", m0_rsp_valid, 1);
        chk("d6_rsp_m1", m1_rsp_valid, 0);
        cyc(); idle();

        // Random traffic; requesters hold a command until it is accepted.
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rst_n = ($urandom_range(0, 149) != 0);
            if (!md_hold0) begin
                m0_cmd_valid = 1'($urandom_range(0, 1));
                m0_cmd_read  = 1'($urandom_range(0, 1));
                m0_cmd_addr  = AW'($urandom);
                m0_cmd_wdata = $urandom;
                m0_cmd_wmask = MW'($urandom_range(0, 15));
            end
            if (!md_hold1) begin
                m1_cmd_valid = 1'($urandom_range(0, 1));
                m1_cmd_read  = 1'($urandom_range(0, 1));
                m1_cmd_addr  = AW'($urandom);
                m1_cmd_wdata = $urandom;
                m1_cmd_wmask = MW'($urandom_range(0, 15));
            end
            dtcm_cmd_ready = ($urandom_range(0, 3) != 0);
            dtcm_rsp_valid = (md_q.size() != 0) && ($urandom_range(0, 2) != 0);
            dtcm_rsp_rdata = $urandom;
            m0_rsp_ready   = ($urandom_range(0, 3) != 0);
            m1_rsp_ready   = ($urandom_range(0, 3) != 0);
        end

        cyc(); idle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
